// File: rtl/gamma_pkg.sv
// Shared types, defaults and width helpers for the gamma cycle sequencer.
package gamma_pkg;

  localparam int unsigned GAMMA_CYCLE_WIDTH_DEF = 16;
  localparam int unsigned PULSE_WIDTH_DEF       = 8;
  localparam int unsigned N_IN_DEF              = 2;
  localparam int unsigned RST_CYCLES_DEF        = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } gamma_state_t;

  // Width of a value/time field for a window of n cycles (at least one bit).
  function automatic int unsigned gamma_vw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Phase counter width: must hold both RESET and RUN tick indices.
  function automatic int unsigned gamma_cw(input int unsigned gcw, input int unsigned rst);
    int unsigned m;
    m = (gcw > rst) ? gcw : rst;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/gamma_cycle_sequencer_spike_encoder.sv
// Binary-to-temporal encoder for one datapath input: registered pulse of
// PULSE_WIDTH ticks starting at tick == val, truncated at the window end.
module spike_encoder
  import gamma_pkg::*;
#(
  parameter int unsigned VW          = 4,
  parameter int unsigned PULSE_WIDTH = PULSE_WIDTH_DEF
) (
  input  logic          aclk,
  input  logic          grst_n,
  input  logic [VW-1:0] tick_i,
  input  logic [VW-1:0] val_i,
  input  logic          en_i,
  input  logic          run_i,
  output logic          spike_o
);

  logic [31:0] tick_w;
  logic [31:0] lo_w;
  logic [31:0] hi_w;
  logic        spike_d;
  logic        spike_q;

  // Window test done in 32 bits so val + PULSE_WIDTH never wraps.
  always_comb begin
    tick_w  = 32'(tick_i);
    lo_w    = 32'(val_i);
    hi_w    = lo_w + 32'(PULSE_WIDTH);
    spike_d = run_i && en_i && (tick_w >= lo_w) && (tick_w < hi_w);
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/gamma_cycle_sequencer.sv
// One gamma cycle per request: latch reset, spike-encode inputs, decode q time.
// Optional GAMMA_BACK2BACK_EN: accept the next request during REPORT.
module gamma_cycle_sequencer
  import gamma_pkg::*;
#(
  parameter  int unsigned GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
  parameter  int unsigned PULSE_WIDTH       = PULSE_WIDTH_DEF,
  parameter  int unsigned N_IN              = N_IN_DEF,
  parameter  int unsigned RST_CYCLES        = RST_CYCLES_DEF,
  localparam int unsigned VW                = gamma_vw(GAMMA_CYCLE_WIDTH)
) (
  input  logic               aclk,
  input  logic               grst_n,
  input  logic               start,
  input  logic [N_IN*VW-1:0] in_val,
  input  logic [N_IN-1:0]    in_vld,
  output logic               ready,
  output logic               blk_rst,
  output logic [N_IN-1:0]    spike_out,
  input  logic               q_in,
  output logic [VW-1:0]      out_time,
  output logic               out_vld,
  output logic               done
);

  localparam int unsigned CW = gamma_cw(GAMMA_CYCLE_WIDTH, RST_CYCLES);
  localparam int unsigned IW = N_IN * VW;

  gamma_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   val_q, val_d;
  logic [N_IN-1:0] vld_q, vld_d;
  logic [VW-1:0]   out_time_q, out_time_d;
  logic            out_vld_q, out_vld_d;
  logic            blk_rst_q, blk_rst_d;
  logic            done_q, done_d;
  logic            accept;
  logic            run_nxt;
  logic [VW-1:0]   tick_nxt;

`ifdef GAMMA_BACK2BACK_EN
  assign ready = (state_q == ST_IDLE) || (state_q == ST_REPORT);
`else
  assign ready = (state_q == ST_IDLE);
`endif

  // Next-state, operand latch, capture and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    val_d      = val_q;
    vld_d      = vld_q;
    out_time_d = out_time_q;
    out_vld_d  = out_vld_q;
    accept     = start && ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      end
      ST_RESET: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(GAMMA_CYCLE_WIDTH - 1)) begin
          state_d = ST_REPORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
`ifdef GAMMA_BACK2BACK_EN
        if (start) begin
          state_d = ST_RESET;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      val_d      = in_val;
      vld_d      = in_vld;
      out_time_d = '0;
      out_vld_d  = 1'b0;
    end else if ((state_q == ST_RUN) && q_in && !out_vld_q) begin
      // First q edge in the window wins; later activity is ignored.
      out_time_d = VW'(cnt_q);
      out_vld_d  = 1'b1;
    end

    blk_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    done_d    = (state_d == ST_REPORT);
    run_nxt   = (state_d == ST_RUN);
    tick_nxt  = VW'(cnt_d);
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      val_q      <= '0;
      vld_q      <= '0;
      out_time_q <= '0;
      out_vld_q  <= 1'b0;
      blk_rst_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      vld_q      <= vld_d;
      out_time_q <= out_time_d;
      out_vld_q  <= out_vld_d;
      blk_rst_q  <= blk_rst_d;
      done_q     <= done_d;
    end
  end

  // Encoders look at the upcoming tick so each pulse flop lines up with its RUN cycle.
  for (genvar i = 0; i < N_IN; i++) begin : g_enc
    spike_encoder #(
      .VW          (VW),
      .PULSE_WIDTH (PULSE_WIDTH)
    ) u_enc (
      .aclk    (aclk),
      .grst_n  (grst_n),
      .tick_i  (tick_nxt),
      .val_i   (val_q[i*VW +: VW]),
      .en_i    (vld_q[i]),
      .run_i   (run_nxt),
      .spike_o (spike_out[i])
    );
  end

  assign blk_rst  = blk_rst_q;
  assign out_time = out_time_q;
  assign out_vld  = out_vld_q;
  assign done     = done_q;

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// Directed scoreboard bench for gamma_cycle_sequencer (default parameters).
module tb_gamma_cycle_sequencer;

  localparam int GCW  = 16;
  localparam int PW   = 8;
  localparam int NI   = 2;
  localparam int RSTC = 2;
  localparam int VW   = 4;
  localparam int IW   = NI * VW;
`ifdef GAMMA_BACK2BACK_EN
  localparam int PER  = RSTC + GCW + 1;
  localparam int GAP  = RSTC;
`else
  localparam int PER  = RSTC + GCW + 2;
  localparam int GAP  = RSTC + 1;
`endif

  logic          aclk = 1'b0;
  logic          grst_n;
  logic          start;
  logic [IW-1:0] in_val;
  logic [NI-1:0] in_vld;
  logic          ready;
  logic          blk_rst;
  logic [NI-1:0] spike_out;
  logic          q_in;
  logic [VW-1:0] out_time;
  logic          out_vld;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;
  int mode        = 0;
  int cyc         = 0;

  typedef struct packed {
    logic [VW-1:0] t;
    logic          v;
  } res_t;
  res_t sb[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Stand-in datapath: 0 = a AND NOT b (a earlier than b), 1 = never fires, else always high.
  always_comb begin
    if (mode == 0)      q_in = spike_out[0] & ~spike_out[1];
    else if (mode == 1) q_in = 1'b0;
    else                q_in = 1'b1;
  end

  gamma_cycle_sequencer #(
    .GAMMA_CYCLE_WIDTH (GCW),
    .PULSE_WIDTH       (PW),
    .N_IN              (NI),
    .RST_CYCLES        (RSTC)
  ) dut (
    .aclk      (aclk),
    .grst_n    (grst_n),
    .start     (start),
    .in_val    (in_val),
    .in_vld    (in_vld),
    .ready     (ready),
    .blk_rst   (blk_rst),
    .spike_out (spike_out),
    .q_in      (q_in),
    .out_time  (out_time),
    .out_vld   (out_vld),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_spk(input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                                         input logic [1:0] en, input int k);
    int v [2];
    v[0] = int'(v0);
    v[1] = int'(v1);
    for (int i = 0; i < 2; i++) begin
      exp_spk[i] = en[i] && (k >= v[i]) && (k < v[i] + PW);
    end
  endfunction

  // One full request; inj_k >= 0 pulses start during RUN tick inj_k.
  task automatic do_req(input logic [VW-1:0] v0, input logic [VW-1:0] v1, input logic [1:0] en,
                        input logic [VW-1:0] et, input logic ev, input int inj_k);
    res_t       r;
    logic [1:0] es;
    logic       eb;
    logic       ed;
    int         seen;
    @(negedge aclk);
    chk("ready_idle", 32'(ready), 32'd1);
    in_val = {v1, v0};
    in_vld = en;
    start  = 1'b1;
    @(posedge aclk);
    sb.push_back('{t: et, v: ev});
    #1;
    start  = 1'b0;
    in_val = IW'($urandom);
    in_vld = ~en;
    for (int c = 0; c <= RSTC + GCW; c++) begin
      @(negedge aclk);
      if (c < RSTC) begin
        es = 2'b00; eb = 1'b1; ed = 1'b0;
      end else if (c < RSTC + GCW) begin
        es = exp_spk(v0, v1, en, c - RSTC); eb = 1'b0; ed = 1'b0;
      end else begin
        es = 2'b00; eb = 1'b0; ed = 1'b1;
      end
      chk($sformatf("c%0d_done_rst_spk", c), 32'({done, blk_rst, spike_out}), 32'({ed, eb, es}));
      if (c == 0) chk("clr_on_accept", 32'({out_vld, out_time}), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk("out_time", 32'(out_time), 32'(r.t));
          chk("out_vld", 32'(out_vld), 32'(r.v));
        end
      end
      start = (inj_k >= 0) && (c == RSTC + inj_k);
    end
    @(negedge aclk);
    chk("idle_after", 32'({ready, done}), 32'(2'b10));
    chk("held_result", 32'({out_vld, out_time}), 32'({ev, et}));
    if (inj_k >= 0) begin
      seen = 0;
      repeat (25) begin
        @(negedge aclk);
        if (done) seen++;
      end
      chk("no_extra_done", 32'(seen), 32'd0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int nd;
    int blk_between;
    int d [3];

    grst_n = 1'b0;
    start  = 1'b0;
    in_val = '0;
    in_vld = '0;
    mode   = 0;
    repeat (3) @(negedge aclk);
    chk("reset_state", 32'({ready, blk_rst, spike_out, done, out_vld, out_time}),
        32'({1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0}));
    @(posedge aclk);
    #2 grst_n = 1'b1;

    mode = 0;
    do_req(4'd3, 4'd5, 2'b11, 4'd3, 1'b1, -1);

    mode = 1;
    do_req(4'd12, 4'd0, 2'b01, 4'd0, 1'b0, -1);

    mode = 2;
    do_req(4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 5);

    mode = 0;
    do_req(4'd0, 4'd9, 2'b10, 4'd0, 1'b0, -1);

    // Abort mid-window at k=7.
    mode = 0;
    @(negedge aclk);
    in_val = {4'd5, 4'd3};
    in_vld = 2'b11;
    start  = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    repeat (RSTC + 7 + 1) @(negedge aclk);
    chk("k7_spike", 32'(spike_out), 32'(2'b11));
    grst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({ready, blk_rst, spike_out, done, out_vld, out_time}),
        32'({1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0}));
    @(negedge aclk);
    grst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge aclk);
      if (done) seen++;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    do_req(4'd3, 4'd5, 2'b11, 4'd3, 1'b1, -1);

    // Start held high: done period and reset gap between windows.
    mode = 0;
    @(negedge aclk);
    in_val = {4'd5, 4'd3};
    in_vld = 2'b11;
    start  = 1'b1;
    nd = 0;
    blk_between = 0;
    for (int n = 0; n < 100 && nd < 3; n++) begin
      @(negedge aclk);
      if (done) begin
        d[nd] = cyc;
        chk("b2b_result", 32'({out_vld, out_time}), 32'({1'b1, 4'd3}));
        nd++;
      end else if (nd == 1 && blk_rst) begin
        blk_between++;
      end
    end
    chk("b2b_done_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      chk("b2b_period1", 32'(d[1] - d[0]), 32'(PER));
      chk("b2b_period2", 32'(d[2] - d[1]), 32'(PER));
    end
    chk("b2b_rst_gap", 32'(blk_between), 32'(GAP));
    start = 1'b0;
    repeat (25) @(negedge aclk);
    chk("b2b_idle", 32'({ready, done, blk_rst}), 32'(3'b101));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
